tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_tick_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared prescaler plus NUM_CH programmable clock-enable strobe channels.
// Channels are reconfigured through a two-state valid/ready port and share pause and sync.

module tick_scheduler_ch #(
    parameter int PER_W      = 16,
    parameter int RST_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w,
    input  logic             pause,
    input  logic             sync,
    input  logic             apply,
    input  logic [PER_W-1:0] ap_period,
    input  logic             ap_en,
    output logic             tick,
    output logic             en
);
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] cnt;

    // Precedence: a config write beats sync, which beats pause and the base tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= PER_W'(RST_PERIOD);
            en     <= 1'b0;
            cnt    <= '0;
            tick   <= 1'b0;
        end else if (apply) begin
            period <= ap_period;
            en     <= ap_en;
            cnt    <= '0;
            tick   <= 1'b0;
        end else if (sync || !en) begin
            cnt    <= '0;
            tick   <= 1'b0;
        end else if (pause || !w) begin
            tick   <= 1'b0;
        end else if (cnt == period - PER_W'(1)) begin
            cnt    <= '0;
            tick   <= 1'b1;
        end else begin
            cnt    <= cnt + PER_W'(1);
            tick   <= 1'b0;
        end
    end
endmodule

module tick_scheduler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BASE_HZ    = 1000,
    parameter int NUM_CH     = 4,
    parameter int PER_W      = 16,
    parameter int RST_PERIOD = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PER_W-1:0]          cfg_period,
    input  logic                      cfg_en,
    input  logic                      pause,
    input  logic                      sync,
    output logic                      base_tick,
    output logic [NUM_CH-1:0]         tick_o,
    output logic [NUM_CH-1:0]         ch_en
);
    localparam int PRE_DIV = CLK_HZ / BASE_HZ;
    localparam int PRE_W   = $clog2(PRE_DIV);
    localparam int CH_W    = $clog2(NUM_CH);

    typedef enum logic {IDLE, APPLY} state_t;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [PER_W-1:0] period;
        logic             en;
    } cfg_req_t;

    logic [PRE_W-1:0] pre_cnt;
    logic             w;
    state_t           state, state_nx;
    logic             cap;
    cfg_req_t         req_q;
    logic [NUM_CH-1:0] apply_vec;

    assign w = (pre_cnt == PRE_W'(PRE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else if (sync) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            pre_cnt   <= w ? '0 : pre_cnt + PRE_W'(1);
            base_tick <= w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            cfg_ready <= (state_nx == IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        case (state)
            IDLE: if (cfg_valid) begin
                cap      = 1'b1;
                state_nx = APPLY;
            end
            APPLY: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Period 0 is folded to 1 at capture so channels never see a zero period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (cap) begin
            req_q.ch     <= cfg_ch;
            req_q.period <= (cfg_period == '0) ? PER_W'(1) : cfg_period;
            req_q.en     <= cfg_en;
        end
    end

    // Out-of-range channel indices match no lane, so the write is silently dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign apply_vec[gi] = (state == APPLY) && (req_q.ch == CH_W'(gi));

        tick_scheduler_ch #(
            .PER_W      (PER_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .w         (w),
            .pause     (pause),
            .sync      (sync),
            .apply     (apply_vec[gi]),
            .ap_period (req_q.period),
            .ap_en     (req_q.en),
            .tick      (tick_o[gi]),
            .en        (ch_en[gi])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed plus randomized bench for tick_scheduler against a count-based reference model.
module tb_tick_scheduler;
    localparam int CLK_HZ  = 1000;
    localparam int BASE_HZ = 100;
    localparam int PRE_DIV = CLK_HZ / BASE_HZ;
    localparam int NCH     = 3;
    localparam int PER_W   = 16;
    localparam int RSTP    = 1000;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [PER_W-1:0] cfg_period;
    logic             cfg_en;
    logic             pause;
    logic             sync;
    logic             base_tick;
    logic [NCH-1:0]   tick_o;
    logic [NCH-1:0]   ch_en;

    tick_scheduler #(
        .CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .NUM_CH(NCH), .PER_W(PER_W), .RST_PERIOD(RSTP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en),
        .pause(pause), .sync(sync), .base_tick(base_tick), .tick_o(tick_o), .ch_en(ch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: edges since phase origin, base ticks counted per channel.
    int             m_edges;
    bit             m_busy;
    int             m_cap_ch;
    int             m_cap_per;
    bit             m_cap_en;
    int             m_per[NCH];
    bit             m_en[NCH];
    int             m_ticks[NCH];
    bit             e_base;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_busy  = 0;
        e_base  = 0;
        e_tick  = '0;
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = RSTP; m_en[i] = 0; m_ticks[i] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NCH; i++) e_en[i] = m_en[i];
        check({tag, ".base_tick"}, base_tick, e_base);
        check({tag, ".tick_o"},    tick_o,    e_tick);
        check({tag, ".ch_en"},     ch_en,     e_en);
        check({tag, ".cfg_ready"}, cfg_ready, !m_busy);
    endtask

    task automatic step(input string tag = "run");
        bit w;
        bit apply_now;
        @(posedge clk);
        apply_now = m_busy;
        w = ((m_edges + 1) % PRE_DIV) == 0;
        if (sync) begin
            m_edges = 0; e_base = 0;
        end else begin
            m_edges++; e_base = (m_edges % PRE_DIV) == 0;
        end
        for (int i = 0; i < NCH; i++) begin
            e_tick[i] = 1'b0;
            if (apply_now && m_cap_ch == i) begin
                m_per[i]   = (m_cap_per == 0) ? 1 : m_cap_per;
                m_en[i]    = m_cap_en;
                m_ticks[i] = 0;
            end else if (sync || !m_en[i]) begin
                m_ticks[i] = 0;
            end else if (!pause && w) begin
                m_ticks[i]++;
                e_tick[i] = (m_ticks[i] % m_per[i]) == 0;
            end
        end
        if (m_busy) m_busy = 0;
        else if (cfg_valid) begin
            m_busy = 1; m_cap_ch = int'(cfg_ch); m_cap_per = int'(cfg_period); m_cap_en = cfg_en;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic cfg(input int ch, input int per, input bit en);
        if (m_busy) step("cfg_wait");
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_period = PER_W'(per); cfg_en = en;
        step("cfg");
        cfg_valid = 0;
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 2 * PRE_DIV && (m_edges % PRE_DIV) != ph; k++) step("phase");
    endtask

    initial begin
        int nb;
        rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_period = 0; cfg_en = 0; pause = 0; sync = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        @(negedge clk) rst_n = 1;

        repeat (50) step("idle");

        cfg(0, 3, 1);
        repeat (45) step("ch0_p3");

        cfg(1, 0, 1);
        wait_phase(8);
        cfg(2, 2, 1);
        repeat (40) step("ch2_on_w");

        cfg(0, 4, 1);
        nb = 0;
        for (int k = 0; k < 4 * PRE_DIV && nb < 2; k++) begin
            step("pre_pause");
            if (e_base) nb++;
        end
        pause = 1;
        repeat (25) step("pause");
        pause = 0;
        repeat (40) step("resume");

        wait_phase(6);
        sync = 1;
        step("sync");
        sync = 0;
        repeat (30) step("post_sync");

        repeat (400) begin
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = PER_W'($urandom_range(0, 5));
            cfg_en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            sync = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        cfg_valid = 0; pause = 0; sync = 0;

        cfg(0, 1, 1);
        wait_phase(9);
        cfg_valid = 1; cfg_ch = 2; cfg_period = 3; cfg_en = 1;
        step("pre_rst");
        cfg_valid = 0;
        #2 rst_n = 0;
        #1;
        check("arst.base_tick", base_tick, 0);
        check("arst.tick_o",    tick_o,    0);
        check("arst.ch_en",     ch_en,     0);
        check("arst.cfg_ready", cfg_ready, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        repeat (30) step("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
